// File: rtl/mb_arb.sv
// rtl/mb_arb.sv - N-channel round-robin memory-bus arbiter onto one single-port synchronous memory
// Define MB_ARB_LOCK_EN to add the per-channel lock input and the LOCKED arbitration state.
module mb_arb #(
  parameter int NCH = 2,
  parameter int DSZ = 8,
  parameter int ASZ = 20 - $clog2(DSZ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req,
  input  logic [NCH-1:0]     we,
  input  logic [NCH*ASZ-1:0] ai,
  input  logic [NCH*DSZ-1:0] vi,
`ifdef MB_ARB_LOCK_EN
  input  logic [NCH-1:0]     lock,
`endif
  output logic [NCH-1:0]     gnt,
  output logic [NCH-1:0]     ack,
  output logic [DSZ-1:0]     vo,
  output logic               mem_we,
  output logic [ASZ-1:0]     mem_ai,
  output logic [DSZ-1:0]     mem_vi,
  input  logic [DSZ-1:0]     mem_vo
);

  localparam int PW = $clog2(NCH);
  localparam logic [NCH-1:0] ONE = {{(NCH-1){1'b0}}, 1'b1};

`ifdef MB_ARB_LOCK_EN
  typedef enum logic {OPEN, LOCKED} lock_st_e;
  lock_st_e      lst_q, lst_d;
  logic [PW-1:0] lch_q, lch_d;
  logic          lock_exit;
  logic          sel_lock;
`endif

  logic [NCH-1:0] gnt_q, gnt_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [NCH-1:0] elig;
  logic           mem_we_q, mem_we_d;
  logic [ASZ-1:0] mem_ai_q, mem_ai_d, sel_ai;
  logic [DSZ-1:0] mem_vi_q, mem_vi_d, sel_vi;
  logic [PW-1:0]  ptr_q, ptr_d, win, idx;
  logic           win_v, sel_we;

  // A channel already showing gnt is still reacting to it, so it cannot be re-issued this cycle.
  always_comb begin
    elig = req & ~gnt_q;
`ifdef MB_ARB_LOCK_EN
    lock_exit = (lst_q == LOCKED) && !(req[lch_q] && lock[lch_q]) && !gnt_q[lch_q];
    if ((lst_q == LOCKED) && !lock_exit) begin
      elig = elig & (ONE << lch_q);
    end
`endif
  end

  always_comb begin
    win_v = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 1; k <= NCH; k++) begin
      idx = PW'((int'(ptr_q) + k) % NCH);
      if (!win_v && elig[idx]) begin
        win_v = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    sel_we = 1'b0;
    sel_ai = '0;
    sel_vi = '0;
`ifdef MB_ARB_LOCK_EN
    sel_lock = 1'b0;
`endif
    for (int k = 0; k < NCH; k++) begin
      if (win == PW'(k)) begin
        sel_we = we[k];
        sel_ai = ai[k*ASZ +: ASZ];
        sel_vi = vi[k*DSZ +: DSZ];
`ifdef MB_ARB_LOCK_EN
        sel_lock = lock[k];
`endif
      end
    end
  end

  // Address and write data hold their last values while idle; only mem_we drops.
  always_comb begin
    gnt_d    = '0;
    ack_d    = gnt_q;
    mem_we_d = win_v & sel_we;
    mem_ai_d = mem_ai_q;
    mem_vi_d = mem_vi_q;
    ptr_d    = ptr_q;
    if (win_v) begin
      gnt_d    = ONE << win;
      mem_ai_d = sel_ai;
      mem_vi_d = sel_vi;
      ptr_d    = win;
    end
`ifdef MB_ARB_LOCK_EN
    lst_d = lst_q;
    lch_d = lch_q;
    if (lock_exit) begin
      lst_d = OPEN;
    end
    if (win_v) begin
      lst_d = sel_lock ? LOCKED : OPEN;
      lch_d = win;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      ack_q    <= '0;
      mem_we_q <= 1'b0;
      mem_ai_q <= '0;
      mem_vi_q <= '0;
      ptr_q    <= PW'(NCH - 1);
`ifdef MB_ARB_LOCK_EN
      lst_q    <= OPEN;
      lch_q    <= '0;
`endif
    end else begin
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      mem_we_q <= mem_we_d;
      mem_ai_q <= mem_ai_d;
      mem_vi_q <= mem_vi_d;
      ptr_q    <= ptr_d;
`ifdef MB_ARB_LOCK_EN
      lst_q    <= lst_d;
      lch_q    <= lch_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign ack    = ack_q;
  assign vo     = mem_vo;
  assign mem_we = mem_we_q;
  assign mem_ai = mem_ai_q;
  assign mem_vi = mem_vi_q;

endmodule

// File: doc/mb_arb.md
Name: mb_arb

Overview:
- Parametrised N-channel memory-bus arbiter. It multiplexes NCH master ports, each of the same we/ai/vi/vo shape as the team's generic memory-bus interface, onto one single-port synchronous memory such as the 128K SPRAM.
- Successor to the fixed 8-bit, single-master bus: data width and channel count are generic, and it adds a request/grant/ack handshake, round-robin fairness and a pipelined one-command-per-cycle issue path.
- Sits between the eForth core masters (instruction fetch, data stack, DMA) and the SPRAM wrapper.

Parameters:
NCH, 2, number of master channels (2..8)
DSZ, 8, data bus width in bits (8, 16 or 32)
ASZ, 20-$clog2(DSZ), address width; 17/16/15 for 128K SPRAM

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NCH  per-channel command request
we  input  NCH  per-channel write enable (1=write, 0=read)
ai  input  NCH*ASZ  per-channel address, channel i at [i*ASZ +: ASZ]
vi  input  NCH*DSZ  per-channel write data, channel i at [i*DSZ +: DSZ]
gnt  output  NCH  one-hot, one-cycle pulse: command accepted
ack  output  NCH  one-hot, one-cycle pulse: access complete, read data valid
vo  output  DSZ  read data, valid when ack[i] and the command was a read
mem_we  output  1  memory write enable
mem_ai  output  ASZ  memory address
mem_vi  output  DSZ  memory write data
mem_vo  input  DSZ  memory read data, 1-cycle synchronous latency

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - gnt=0, ack=0, mem_we=0, mem_ai=0, mem_vi=0.
  - RR pointer = NCH-1, so channel 0 has first priority.
  - Pipeline valid bits are cleared.
  - Reset mid-operation drops any in-flight ack; no pulse follows reset release.
- Pipeline, command arbitrated in cycle T:
  - T: combinational arbitration over eligible req. Search order starts at ptr+1 mod NCH; first asserted channel w wins.
  - T+1: registered outputs gnt[w]=1, mem_we=we[w], mem_ai=ai[w], mem_vi=vi[w]. The RR pointer updates to w.
  - T+2: ack[w]=1. vo = mem_vo (combinational pass-through). For writes, ack still pulses and vo is don't-care.
  - Latency req->gnt is 1 cycle; req->ack is 2 cycles. Throughput is one command per cycle across channels.
- Eligibility:
  - A channel whose gnt is high in the current cycle is masked from arbitration in that cycle. This prevents a duplicate issue while the master is still reacting to gnt.
  - Consequence: a single channel issues at most every other cycle; two channels interleave at full rate.
- Master rule: hold req/we/ai/vi stable from assertion until the cycle gnt is seen. In the cycle after gnt, present a new command or drop req.
- Idle: no eligible req gives mem_we=0 next cycle. mem_ai/mem_vi hold their last values and the pointer does not move.
- Simultaneous events:
  - gnt for the new command and ack for the previous command may be high together, on different or the same channel.
  - A write followed by a read to the same address from any channel returns the new data, since the memory is in order.
- No internal state machine beyond the pipeline valid regs, pointer and lock state. Widths are fixed by parameters; no data width conversion.

Optional Feature:
- Macro: MB_ARB_LOCK_EN.
- Enabled:
  - Adds input port lock (NCH bits).
  - If lock[w] is high when w wins, the arbiter enters LOCKED(w) and only channel w is eligible. Other requests stall; idle cycles are not given away.
  - Locked channel still obeys the gnt-mask rule.
  - Exits to OPEN in any arbitration cycle where req[w]&lock[w]=0 and gnt[w]=0; RR resumes from w+1. Reset forces OPEN.
- Disabled: lock port absent, pure round-robin, no LOCKED state.

Test Plan:
- Reset, then ch0 reads addr 0x00010 (preloaded 0xA5) -> gnt[0] at T+1, mem_ai=0x00010, mem_we=0; ack[0] and vo=0xA5 at T+2.
- ch0 and ch1 both req continuously from T -> gnts alternate 0,1,0,1 each cycle; ack follows gnt by exactly 1 cycle; no channel granted twice in a row.
- ch1 writes 0x3C to 0x00100 at T, ch0 reads 0x00100 at T+1 -> mem_we=1 at T+1; ack[0] at T+3 with vo=0x3C.
- NCH=4, DSZ=16, all four req held -> grant order 0,1,2,3,0; each channel's first gnt within 4 cycles.
- Assert rst_n=0 the cycle after gnt[1] -> ack all 0 immediately and after release; next grant goes to ch0.
- MB_ARB_LOCK_EN: ch2 wins with lock=1 and issues 3 commands while ch0 reqs -> ch0 gets no gnt until ch2 drops lock; ch0 granted on the first cycle it becomes eligible after lock release.
